pfb_tap_accumulator: RTL and testbench
======================================

Name: pfb_tap_accumulator

Overview:
- Downstream of the PFB multichannel decimator's tap multiplier; consumes its unsigned 26-bit coefficient×sample products.
- Sums TAPS consecutive products per channel, emits one filtered sample per channel in round-robin order with channel tag and frame-last marker.
- Valid/ready streaming on both sides; feeds the FFT input reorder stage.

Parameters:
- PROD_WIDTH, 26, width of unsigned input product.
- TAPS, 8, products summed per output sample (≥1).
- CHANNELS, 16, channels per frame (≥2, power of two not required).
- ACC_WIDTH, 29, accumulator/output width; must be ≥ PROD_WIDTH+clog2(TAPS).
- ROUND_SHIFT, 4, LSBs dropped when PFB_ACC_ROUND_EN is defined (<ACC_WIDTH).

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst  in  1  asynchronous active-high reset.
- in_data  in  PROD_WIDTH  unsigned product.
- in_valid  in  1  in_data valid.
- in_sof  in  1  qualifies beat as tap 0 of channel 0.
- in_ready  out  1  block can accept.
- out_data  out  ACC_WIDTH  accumulated sum.
- out_chan  out  clog2(CHANNELS)  channel index of out_data.
- out_last  out  1  high with channel CHANNELS-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- sync_err  out  1  sticky framing error.

Behaviour:
- Reset (async assert, sync release): tap_cnt=0, chan_cnt=0, acc=0, out_data=0, out_chan=0, out_last=0, out_valid=0, sync_err=0; in_ready=1 after reset. Mid-operation reset discards partial sums and any held output.
- Accept: in_valid && in_ready. in_ready = !(out_valid && !out_ready) (combinational; one output register, 100% throughput when out_ready=1).
- Input order: per channel, taps 0..TAPS-1 consecutively; channels 0..CHANNELS-1 then wrap.
- On accept with effective tap 0: acc ← in_data (no add). Other taps: acc ← acc + in_data, unsigned, zero-extended to ACC_WIDTH, no overflow possible by width rule.
- On accept of tap TAPS-1: out_data ← acc + in_data (in_data alone if TAPS=1), out_chan ← chan_cnt, out_last ← (chan_cnt==CHANNELS-1), out_valid ← 1; tap_cnt ← 0; chan_cnt ← chan_cnt+1, wrapping CHANNELS-1→0. Latency: out_valid one cycle after last-tap accept.
- Otherwise tap_cnt increments on accept; counters hold when no accept.
- Output: out_valid cleared on out_valid && out_ready unless a new last-tap accept loads it in the same cycle (load wins, out_valid stays 1). Output fields stable while out_valid && !out_ready.
- in_sof on an accepted beat: beat treated as tap 0 of channel 0 (acc ← in_data, tap_cnt ← 1 or emit if TAPS=1, chan_cnt forced 0). If tap_cnt≠0 or chan_cnt≠0 at that moment, sync_err ← 1 (sticky until reset); partial sum discarded. in_sof with !in_valid ignored.

Optional Feature:
- Macro PFB_ACC_ROUND_EN defined: loaded out_data = min((sum + 2^(ROUND_SHIFT-1)) >> ROUND_SHIFT, 2^(ACC_WIDTH-ROUND_SHIFT)-1), zero-extended to ACC_WIDTH (round-half-up, saturating). Rounding adder sits in the load path; latency unchanged.
- Not defined: out_data = full-precision sum; no rounding logic.

Test Plan:
- Reset, then in_sof on first beat, 8 products of 1000 for ch0, out_ready=1 -> out_data=8000, out_chan=0, out_last=0, out_valid 1 cycle after 8th accept; sync_err=0.
- 16 channels × 8 taps of 0x3FFFFFF, out_ready=1 -> 16 beats each 0x1FFFFFF8, out_chan 0..15, out_last only on ch15, no in_ready drop.
- Hold out_ready=0 after ch0 emits -> in_ready=0, ch1 taps stalled, out_data stays 8000; release -> ch1 result follows, no beat lost/duplicated.
- in_sof asserted at tap 3 of ch5 -> sync_err=1 sticky, next emitted beat has out_chan=0 and sum of the 8 beats from the sof onward.
- Assert ap_rst mid-channel with out_valid=1 -> all outputs 0 immediately (async); next frame sums correct.
- PFB_ACC_ROUND_EN, ROUND_SHIFT=4: taps summing to 8008 -> out_data=501; sum 8 -> 1; sum 7 -> 0.

Source files
------------

// File: rtl/pfb_tap_accumulator_if.sv
// pfb_tap_accumulator_if: product input stream and accumulated-sample output stream of the PFB tap accumulator.
// Input stream:  in_data (unsigned product), in_valid, in_sof (tap 0 of channel 0), in_ready.
// Output stream: out_data (sum), out_chan (channel tag), out_last (final channel), out_valid, out_ready.
// master: producer of in_* / consumer of out_* ; slave: the accumulator itself.
interface pfb_tap_accumulator_if #(
    parameter int PROD_WIDTH = 26,
    parameter int ACC_WIDTH  = 29,
    parameter int CHANNELS   = 16
);
    localparam int CW = $clog2(CHANNELS);
    logic [PROD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_sof;
    logic                  in_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic [CW-1:0]         out_chan;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, out_data, out_chan, out_last, out_valid
    );
    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, out_data, out_chan, out_last, out_valid
    );
endinterface

// File: rtl/pfb_tap_accumulator.sv
// pfb_tap_accumulator: sums TAPS consecutive products per channel and emits one tagged sample per channel, round-robin.
// Ports: ap_clk (rising edge), ap_rst (async active-high), bus (slave side of pfb_tap_accumulator_if),
//        sync_err (sticky: in_sof arrived while not at tap 0 of channel 0).
// Optional: define PFB_ACC_ROUND_EN to round-half-up and saturate the loaded sum by ROUND_SHIFT bits.
module pfb_tap_accumulator #(
    parameter int PROD_WIDTH  = 26,
    parameter int TAPS        = 8,
    parameter int CHANNELS    = 16,
    parameter int ACC_WIDTH   = 29,
    parameter int ROUND_SHIFT = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    pfb_tap_accumulator_if.slave  bus,
    output logic                  sync_err
);
    localparam int TW = TAPS > 1 ? $clog2(TAPS) : 1;
    localparam int CW = $clog2(CHANNELS);

    logic [TW-1:0]        tap_cnt, tap_eff;
    logic [CW-1:0]        chan_cnt, chan_eff;
    logic [ACC_WIDTH-1:0] acc, sum, load;
    logic                 accept, last_tap, last_chan;

    // Single output register: input stalls only while a beat is held unaccepted.
    assign bus.in_ready = !(bus.out_valid && !bus.out_ready);

    // in_sof overrides the counters so the beat is treated as tap 0 of channel 0.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        tap_eff   = bus.in_sof ? '0 : tap_cnt;
        chan_eff  = bus.in_sof ? '0 : chan_cnt;
        last_tap  = tap_eff == TW'(TAPS - 1);
        last_chan = chan_eff == CW'(CHANNELS - 1);
        sum       = (tap_eff == '0 ? '0 : acc) + ACC_WIDTH'(bus.in_data);
    end

`ifdef PFB_ACC_ROUND_EN
    // One extra bit catches the carry of the rounding add, which is exactly the saturation case.
    logic [ACC_WIDTH:0] rnd;
    always_comb begin
        rnd  = {1'b0, sum} + (ACC_WIDTH + 1)'(2 ** (ROUND_SHIFT - 1));
        load = rnd[ACC_WIDTH] ? {{ROUND_SHIFT{1'b0}}, {(ACC_WIDTH - ROUND_SHIFT){1'b1}}}
                              : ACC_WIDTH'(rnd[ACC_WIDTH-1:ROUND_SHIFT]);
    end
`else
    assign load = sum;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tap_cnt       <= '0;
            chan_cnt      <= '0;
            acc           <= '0;
            sync_err      <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= sum;
                tap_cnt  <= last_tap ? '0 : tap_eff + 1'b1;
                chan_cnt <= !last_tap ? chan_eff : last_chan ? '0 : chan_eff + 1'b1;
                if (bus.in_sof && (tap_cnt != '0 || chan_cnt != '0))
                    sync_err <= 1'b1;
            end
            // A new load wins over a same-cycle handoff of the previous beat.
            if (accept && last_tap) begin
                bus.out_data  <= load;
                bus.out_chan  <= chan_eff;
                bus.out_last  <= last_chan;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pfb_tap_accumulator.sv
// tb_pfb_tap_accumulator: directed-vector bench for pfb_tap_accumulator (default 26-bit products, 8 taps, 16 channels).
module tb_pfb_tap_accumulator;
    localparam int PW = 26, AW = 29, CH = 16, TAPS = 8, RS = 4;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic sync_err;
    int   total = 0;
    int   bad = 0;
    int   stalls = 0;

    pfb_tap_accumulator_if #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CHANNELS(CH)) bus ();

    pfb_tap_accumulator #(
        .PROD_WIDTH(PW), .TAPS(TAPS), .CHANNELS(CH), .ACC_WIDTH(AW), .ROUND_SHIFT(RS)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .bus     (bus),
        .sync_err(sync_err)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [3:0]    c;
        logic          l;
    } beat_t;

    beat_t q[$];

    // Handshake is decided by values stable at the falling edge; record beats there.
    always @(negedge ap_clk)
        if (!ap_rst && bus.out_valid && bus.out_ready)
            q.push_back('{d: bus.out_data, c: bus.out_chan, l: bus.out_last});

    function automatic logic [AW-1:0] exp_out(input longint s);
`ifdef PFB_ACC_ROUND_EN
        longint r = (s + 2 ** (RS - 1)) >>> RS;
        longint mx = 2 ** (AW - RS) - 1;
        return AW'(r > mx ? mx : r);
`else
        return AW'(s);
`endif
    endfunction

    task automatic send(input logic [PW-1:0] d, input logic sof);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        @(negedge ap_clk);
        for (int i = 0; !bus.in_ready; i++) begin
            if (i == 200) begin
                total++; bad++;
                $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
                break;
            end
            stalls++;
            @(negedge ap_clk);
        end
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_chan(input logic [PW-1:0] d, input logic sof, input int n);
        for (int i = 0; i < n; i++) send(d, sof && i == 0);
    endtask

    task automatic do_reset;
        ap_rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        q.delete();
        stalls = 0;
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
        total++; if (bus.out_chan !== '0) begin bad++; $display("FAIL rst_out_chan got=%h want=0", bus.out_chan); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", bus.out_last); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err got=%b want=0", sync_err); end
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_single_channel;
        do_reset();
        send(1000, 1'b1);
        repeat (6) send(1000, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", bus.out_valid); end
        send(1000, 1'b0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", bus.out_valid); end
        total++; if (bus.out_data !== exp_out(8000)) begin bad++; $display("FAIL single_data got=%0d want=%0d", bus.out_data, exp_out(8000)); end
        total++; if (bus.out_chan !== 4'd0) begin bad++; $display("FAIL single_chan got=%0d want=0", bus.out_chan); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL single_last got=%b want=0", bus.out_last); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL single_sync_err got=%b want=0", sync_err); end
        repeat (3) @(posedge ap_clk);
        #1;
        total++; if (q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", q.size()); end
    endtask

    task automatic test_full_frame;
        beat_t e;
        do_reset();
        for (int c = 0; c < CH; c++) send_chan(26'h3FFFFFF, c == 0, TAPS);
        repeat (3) @(posedge ap_clk);
        #1;
        total++; if (stalls != 0) begin bad++; $display("FAIL frame_in_ready_drops got=%0d want=0", stalls); end
        total++; if (q.size() != CH) begin bad++; $display("FAIL frame_count got=%0d want=%0d", q.size(), CH); end
        for (int i = 0; i < q.size() && i < CH; i++) begin
            e = '{d: exp_out(64'h1FFFFFF8), c: 4'(i), l: i == CH - 1};
            total++; if (q[i] !== e) begin bad++; $display("FAIL frame_beat%0d got=%h want=%h", i, q[i], e); end
        end
    endtask

    task automatic test_backpressure;
        beat_t e0, e1;
        do_reset();
        send_chan(1000, 1'b1, TAPS);
        bus.out_ready = 1'b0;
        bus.in_data = 2000;
        bus.in_valid = 1'b1;
        repeat (5) @(posedge ap_clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.out_data !== exp_out(8000)) begin bad++; $display("FAIL bp_hold_data got=%0d want=%0d", bus.out_data, exp_out(8000)); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL bp_leak got=%0d want=0", q.size()); end
        bus.out_ready = 1'b1;
        send_chan(2000, 1'b0, TAPS);
        repeat (3) @(posedge ap_clk);
        #1;
        e0 = '{d: exp_out(8000), c: 4'd0, l: 1'b0};
        e1 = '{d: exp_out(16000), c: 4'd1, l: 1'b0};
        total++; if (q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", q.size()); end
        if (q.size() >= 2) begin
            total++; if (q[0] !== e0) begin bad++; $display("FAIL bp_beat0 got=%h want=%h", q[0], e0); end
            total++; if (q[1] !== e1) begin bad++; $display("FAIL bp_beat1 got=%h want=%h", q[1], e1); end
        end
    endtask

    task automatic test_sof_resync;
        beat_t e;
        do_reset();
        for (int c = 0; c < 5; c++) send_chan(10, c == 0, TAPS);
        repeat (3) send(10, 1'b0);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sof_pre_err got=%b want=0", sync_err); end
        send(100, 1'b1);
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sof_err got=%b want=1", sync_err); end
        repeat (7) send(100, 1'b0);
        send_chan(5, 1'b0, TAPS);
        repeat (3) @(posedge ap_clk);
        #1;
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sof_err_sticky got=%b want=1", sync_err); end
        total++; if (q.size() != 7) begin bad++; $display("FAIL sof_count got=%0d want=7", q.size()); end
        for (int i = 0; i < q.size() && i < 7; i++) begin
            e = i < 5 ? '{d: exp_out(80), c: 4'(i), l: 1'b0}
              : i == 5 ? '{d: exp_out(800), c: 4'd0, l: 1'b0} : '{d: exp_out(40), c: 4'd1, l: 1'b0};
            total++; if (q[i] !== e) begin bad++; $display("FAIL sof_beat%0d got=%h want=%h", i, q[i], e); end
        end
    endtask

    task automatic test_async_reset;
        beat_t e0, e1;
        do_reset();
        bus.out_ready = 1'b0;
        send_chan(3, 1'b1, TAPS);
        #2;
        total++; if (bus.out_data !== exp_out(24) || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL arst_pre got=%0d/%b want=%0d/1", bus.out_data, bus.out_valid, exp_out(24));
        end
        ap_rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL arst_out_data got=%h want=0", bus.out_data); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", bus.in_ready); end
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        bus.out_ready = 1'b1;
        send_chan(1, 1'b1, TAPS);
        repeat (3) send(999, 1'b0);
        #2;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        q.delete();
        send_chan(7, 1'b1, TAPS);
        send_chan(11, 1'b0, TAPS);
        repeat (3) @(posedge ap_clk);
        #1;
        e0 = '{d: exp_out(56), c: 4'd0, l: 1'b0};
        e1 = '{d: exp_out(88), c: 4'd1, l: 1'b0};
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL arst_sync_err got=%b want=0", sync_err); end
        total++; if (q.size() != 2) begin bad++; $display("FAIL arst_count got=%0d want=2", q.size()); end
        if (q.size() >= 2) begin
            total++; if (q[0] !== e0) begin bad++; $display("FAIL arst_beat0 got=%h want=%h", q[0], e0); end
            total++; if (q[1] !== e1) begin bad++; $display("FAIL arst_beat1 got=%h want=%h", q[1], e1); end
        end
    endtask

`ifdef PFB_ACC_ROUND_EN
    task automatic test_rounding;
        do_reset();
        send(1000, 1'b1);
        repeat (6) send(1000, 1'b0);
        send(1008, 1'b0);
        send_chan(1, 1'b0, TAPS);
        repeat (7) send(1, 1'b0);
        send(0, 1'b0);
        repeat (3) @(posedge ap_clk);
        #1;
        total++; if (q.size() != 3) begin bad++; $display("FAIL rnd_count got=%0d want=3", q.size()); end
        if (q.size() >= 3) begin
            total++; if (q[0].d !== 29'd501) begin bad++; $display("FAIL rnd_8008 got=%0d want=501", q[0].d); end
            total++; if (q[1].d !== 29'd1) begin bad++; $display("FAIL rnd_8 got=%0d want=1", q[1].d); end
            total++; if (q[2].d !== 29'd0) begin bad++; $display("FAIL rnd_7 got=%0d want=0", q[2].d); end
        end
    endtask
`endif

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_channel();
        test_full_frame();
        test_backpressure();
        test_sof_resync();
        test_async_reset();
`ifdef PFB_ACC_ROUND_EN
        test_rounding();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
